// File: rtl/alimentador_vetores_pkg.sv
// Shared types and default sizes for the feeder of the 8-element dot-product unit.
package alimentador_pkg;

    localparam int N_ELEM_PADRAO   = 8;
    localparam int LARG_PADRAO     = 32;
    localparam int LARG_RES_PADRAO = 64;

    typedef enum logic [1:0] {
        CARREGANDO = 2'd0,
        DISPARO    = 2'd1,
        LIBERA     = 2'd2,
        ENTREGA    = 2'd3
    } estado_alim_t;

endpackage

// File: rtl/alimentador_vetores.sv
// Collects a0..a7, b0..b7 from a valid/ready stream, runs the iniciar/concluido
// handshake with the dot-product unit and returns its result on a valid/ready port.
module alimentador_vetores
    import alimentador_pkg::*;
#(
    parameter int N_ELEM   = N_ELEM_PADRAO,
    parameter int LARG     = LARG_PADRAO,
    parameter int LARG_RES = LARG_RES_PADRAO
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [LARG-1:0]          s_dado_i,
    input  logic                     s_ultimo_i,
    input  logic                     limpar_i,
    output logic [N_ELEM*LARG-1:0]   a_o,
    output logic [N_ELEM*LARG-1:0]   b_o,
    output logic                     iniciar_o,
    input  logic                     concluido_i,
    input  logic [LARG_RES-1:0]      resultado_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [LARG_RES-1:0]      m_dado_o,
    output logic                     erro_o,
    output logic [15:0]              n_ops_o
);

    localparam int IDX_W = $clog2(2 * N_ELEM);
    localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(2 * N_ELEM - 1);

    estado_alim_t          estado_q, estado_d;
    logic [IDX_W-1:0]      indice_q, indice_d;
    logic                  iniciar_q, iniciar_d;
    logic                  m_valid_q, m_valid_d;
    logic [LARG_RES-1:0]   m_dado_q, m_dado_d;
    logic                  erro_q, erro_d;
    logic [15:0]           n_ops_q, n_ops_d;
    logic [LARG-1:0]       a_q [N_ELEM];
    logic [LARG-1:0]       b_q [N_ELEM];
    logic                  aceita;
    logic                  grava;

    assign s_ready_o = (estado_q == CARREGANDO);
    assign aceita    = s_valid_i && s_ready_o;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        estado_d  = estado_q;
        indice_d  = indice_q;
        iniciar_d = iniciar_q;
        m_valid_d = m_valid_q;
        m_dado_d  = m_dado_q;
        erro_d    = erro_q;
        n_ops_d   = n_ops_q;
        grava     = 1'b0;

        if (limpar_i) begin
            erro_d = 1'b0;
        end

        case (estado_q)
            CARREGANDO: begin
                iniciar_d = 1'b0;
                m_valid_d = 1'b0;
                if (limpar_i) begin
                    indice_d = '0;
                end else if (aceita) begin
                    // The end-of-frame marker must land exactly on the last index.
                    if (s_ultimo_i != (indice_q == IDX_ULTIMO)) begin
                        erro_d   = 1'b1;
                        indice_d = '0;
                    end else begin
                        grava    = 1'b1;
                        indice_d = indice_q + IDX_W'(1);
                        if (s_ultimo_i) begin
                            estado_d  = DISPARO;
                            iniciar_d = 1'b1;
                        end
                    end
                end
            end
            DISPARO: begin
                iniciar_d = 1'b1;
                if (concluido_i) begin
                    m_dado_d  = resultado_i;
                    iniciar_d = 1'b0;
                    estado_d  = LIBERA;
                end
            end
            LIBERA: begin
                if (!concluido_i) begin
                    m_valid_d = 1'b1;
                    n_ops_d   = n_ops_q + 16'd1;
                    estado_d  = ENTREGA;
                end
            end
            ENTREGA: begin
                if (m_valid_q && m_ready_i) begin
                    m_valid_d = 1'b0;
                    indice_d  = '0;
                    estado_d  = CARREGANDO;
                end
            end
            default: begin
                estado_d  = CARREGANDO;
                iniciar_d = 1'b0;
                m_valid_d = 1'b0;
                indice_d  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= CARREGANDO;
            indice_q  <= '0;
            iniciar_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_dado_q  <= '0;
            erro_q    <= 1'b0;
            n_ops_q   <= '0;
        end else begin
            estado_q  <= estado_d;
            indice_q  <= indice_d;
            iniciar_q <= iniciar_d;
            m_valid_q <= m_valid_d;
            m_dado_q  <= m_dado_d;
            erro_q    <= erro_d;
            n_ops_q   <= n_ops_d;
        end
    end

    // NOTE: the element arrays are reset on purpose: a_o/b_o drive the
    // dot-product unit directly and must read zero after reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ELEM; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (grava) begin
            for (int k = 0; k < N_ELEM; k++) begin
                if (indice_q == IDX_W'(k)) begin
                    a_q[k] <= s_dado_i;
                end
                if (indice_q == IDX_W'(N_ELEM + k)) begin
                    b_q[k] <= s_dado_i;
                end
            end
        end
    end

    for (genvar g = 0; g < N_ELEM; g++) begin : g_achata
        assign a_o[g*LARG +: LARG] = a_q[g];
        assign b_o[g*LARG +: LARG] = b_q[g];
    end

    assign iniciar_o = iniciar_q;
    assign m_valid_o = m_valid_q;
    assign m_dado_o  = m_dado_q;
    assign erro_o    = erro_q;
    assign n_ops_o   = n_ops_q;

endmodule

// File: tb/tb_alimentador_vetores.sv
// Scoreboard bench for alimentador_vetores with a behavioural dot-product unit attached.
module tb_alimentador_vetores;
    import alimentador_pkg::*;

    localparam int N  = 8;
    localparam int L  = 32;
    localparam int LR = 64;

    logic            clk_i = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid_i = 1'b0;
    logic            s_ready_o;
    logic [L-1:0]    s_dado_i = '0;
    logic            s_ultimo_i = 1'b0;
    logic            limpar_i = 1'b0;
    logic [N*L-1:0]  a_o;
    logic [N*L-1:0]  b_o;
    logic            iniciar_o;
    logic            concluido_i;
    logic [LR-1:0]   resultado_i;
    logic            m_valid_o;
    logic            m_ready_i = 1'b1;
    logic [LR-1:0]   m_dado_o;
    logic            erro_o;
    logic [15:0]     n_ops_o;

    alimentador_vetores dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_dado_i    (s_dado_i),
        .s_ultimo_i  (s_ultimo_i),
        .limpar_i    (limpar_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .iniciar_o   (iniciar_o),
        .concluido_i (concluido_i),
        .resultado_i (resultado_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_dado_o    (m_dado_o),
        .erro_o      (erro_o),
        .n_ops_o     (n_ops_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [LR-1:0] dado;
        logic [15:0]   n_ops;
    } esperado_t;

    esperado_t   exp_q[$];
    int          passed = 0;
    int          total  = 0;
    logic [L-1:0] va [N];
    logic [L-1:0] vb [N];

    task automatic check(input string nome, input logic [LR-1:0] atual, input logic [LR-1:0] req);
        total++;
        if (atual === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nome, atual, req);
    endtask

    // Dot-product unit model: raises concluido 4 cycles into iniciar, drops it
    // the cycle after iniciar falls.
    function automatic logic [LR-1:0] produto(input logic [N*L-1:0] a, input logic [N*L-1:0] b);
        logic signed [LR-1:0] s;
        logic signed [LR-1:0] x;
        logic signed [LR-1:0] y;
        s = '0;
        for (int k = 0; k < N; k++) begin
            x = $signed(a[k*L +: L]);
            y = $signed(b[k*L +: L]);
            s = s + x * y;
        end
        return s;
    endfunction

    int lat_cnt;
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            concluido_i <= 1'b0;
            resultado_i <= '0;
            lat_cnt     <= 0;
        end else if (!iniciar_o) begin
            concluido_i <= 1'b0;
            lat_cnt     <= 0;
        end else if (!concluido_i) begin
            lat_cnt <= lat_cnt + 1;
            if (lat_cnt == 3) begin
                concluido_i <= 1'b1;
                resultado_i <= produto(a_o, b_o);
            end
        end
    end

    // Monitor: every result handshake is compared against the scoreboard head.
    initial begin
        esperado_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n && m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL resultado_inesperado: got 0x%0h, required no result", m_dado_o);
                end else begin
                    e = exp_q.pop_front();
                    check("m_dado", m_dado_o, e.dado);
                    check("n_ops_no_resultado", 64'(n_ops_o), 64'(e.n_ops));
                end
            end
        end
    end

    task automatic send_word(input logic [L-1:0] d, input logic u);
        int g;
        g = 0;
        @(negedge clk_i);
        s_valid_i  = 1'b1;
        s_dado_i   = d;
        s_ultimo_i = u;
        while (!s_ready_o && g < 300) begin
            @(negedge clk_i);
            g++;
        end
        if (g >= 300) begin
            total++;
            $display("FAIL timeout_s_ready: got s_ready_o=0, required 1 within 300 cycles");
        end
        @(posedge clk_i);
        #1;
        s_valid_i  = 1'b0;
        s_ultimo_i = 1'b0;
    endtask

    task automatic send_frame();
        for (int k = 0; k < 2*N; k++) begin
            if (k == 2*N-1) check("iniciar_antes_do_ultimo", 64'(iniciar_o), 64'd0);
            send_word(k < N ? va[k] : vb[k-N], k == 2*N-1);
        end
        check("iniciar_apos_16o", 64'(iniciar_o), 64'd1);
    endtask

    task automatic push_exp(input logic [LR-1:0] d, input logic [15:0] n);
        esperado_t e;
        e.dado  = d;
        e.n_ops = n;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk_i);
            g++;
        end
        check("scoreboard_vazio", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_limpar();
        @(negedge clk_i);
        limpar_i = 1'b1;
        @(posedge clk_i);
        #1;
        limpar_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic viu;
        int   g;

        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        check("reset_s_ready", 64'(s_ready_o), 64'd1);
        check("reset_iniciar", 64'(iniciar_o), 64'd0);
        check("reset_m_valid", 64'(m_valid_o), 64'd0);
        check("reset_erro", 64'(erro_o), 64'd0);
        check("reset_n_ops", 64'(n_ops_o), 64'd0);
        check("reset_m_dado", m_dado_o, 64'd0);
        check("reset_a_o", 64'(|a_o), 64'd0);

        // 1..8 . ones = 36
        for (int k = 0; k < N; k++) begin va[k] = L'(k+1); vb[k] = 32'd1; end
        push_exp(64'd36, 16'd1);
        send_frame();
        wait_empty();
        check("n_ops_1", 64'(n_ops_o), 64'd1);
        check("s_ready_apos_1", 64'(s_ready_o), 64'd1);

        // eight -1 . eight 2 = -16
        for (int k = 0; k < N; k++) begin va[k] = 32'hFFFF_FFFF; vb[k] = 32'd2; end
        push_exp(64'hFFFF_FFFF_FFFF_FFF0, 16'd2);
        send_frame();
        wait_empty();

        // Premature end marker on word 5
        for (int k = 0; k < 5; k++) send_word(32'd7, k == 4);
        check("erro_quadro", 64'(erro_o), 64'd1);
        check("s_ready_apos_erro", 64'(s_ready_o), 64'd1);
        viu = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (iniciar_o) viu = 1'b1;
        end
        check("iniciar_apos_erro", 64'(viu), 64'd0);
        for (int k = 0; k < N; k++) begin va[k] = 32'd3; vb[k] = 32'd3; end
        push_exp(64'd72, 16'd3);
        send_frame();
        wait_empty();
        check("erro_pegajoso", 64'(erro_o), 64'd1);
        pulse_limpar();
        check("erro_limpo", 64'(erro_o), 64'd0);

        // Consumer stalls for 10 cycles: 5s . 1..8 = 180
        m_ready_i = 1'b0;
        for (int k = 0; k < N; k++) begin va[k] = 32'd5; vb[k] = L'(k+1); end
        push_exp(64'd180, 16'd4);
        send_frame();
        g = 0;
        while (!m_valid_o && g < 300) begin
            @(negedge clk_i);
            g++;
        end
        check("m_valid_chegou", 64'(m_valid_o), 64'd1);
        viu = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!m_valid_o || m_dado_o !== 64'd180 || s_ready_o) viu = 1'b0;
            @(negedge clk_i);
        end
        check("estavel_durante_espera", 64'(viu), 64'd1);
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("s_ready_apos_entrega", 64'(s_ready_o), 64'd1);
        check("m_valid_apos_entrega", 64'(m_valid_o), 64'd0);
        wait_empty();

        // Partial frame discarded by limpar, then 2s . 2s = 32
        for (int k = 0; k < 7; k++) send_word(32'd9, 1'b0);
        pulse_limpar();
        for (int k = 0; k < N; k++) begin va[k] = 32'd2; vb[k] = 32'd2; end
        push_exp(64'd32, 16'd5);
        send_frame();
        wait_empty();
        check("erro_apos_limpar", 64'(erro_o), 64'd0);

        // Reset during computation
        for (int k = 0; k < N; k++) begin va[k] = L'(k+1); vb[k] = L'(k+1); end
        send_frame();
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        check("rst_iniciar", 64'(iniciar_o), 64'd0);
        check("rst_m_valid", 64'(m_valid_o), 64'd0);
        check("rst_n_ops", 64'(n_ops_o), 64'd0);
        check("rst_s_ready", 64'(s_ready_o), 64'd1);
        @(negedge clk_i);
        rst_n = 1'b1;
        push_exp(64'd204, 16'd1);
        send_frame();
        wait_empty();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
